// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: mode encodings, port IDs, default widths.
// No logic; latency and backpressure are defined by the modules that import it.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mode_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/mem_arb_core.sv
// Two-port arbitration and memory command mux; no mode state, purely combinational.
// Latency: grant and mem_* in the same cycle as the request; the losing port sees gnt=0 and retries.
module mem_arb_core
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              cpu_en,
  input  logic              ld_en,
  input  logic              cpu_first,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              cpu_gnt,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  logic cpu_vld;
  logic ld_vld;

  assign cpu_vld = cpu_en & cpu_req;
  assign ld_vld  = ld_en & ld_req;

  // cpu_first only matters when both ports are eligible in the same cycle
  assign cpu_gnt = cpu_vld & (~ld_vld | cpu_first);
  assign ld_gnt  = ld_vld & ~cpu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Boot/run/drain mode machine sharing data memory between CPU and loader; MEM_ARB_RR_EN selects round-robin conflicts.
// Latency: 0-cycle grant, 1-cycle gnt->rvalid; losers and ports barred by the mode simply see gnt=0 until served.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reload_req,
  input  logic              ld_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_gnt,
  output logic              ld_gnt,
  output logic              cpu_rvalid,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] ld_count
);

  mode_e             state;
  mode_e             state_nxt;
  logic              cpu_pend;
  logic              ld_pend;
  logic              cpu_pend_nxt;
  logic              ld_pend_nxt;
  logic              cpu_en;
  logic              ld_en;
  logic              cpu_first;
  logic [ADDR_W-1:0] cnt;

  // Reset gates the enables so nothing is granted while it is held
  assign cpu_en = ~reset & (state == RUN);
  assign ld_en  = ~reset & ((state == BOOT) | (state == RUN));

`ifdef MEM_ARB_RR_EN
  logic last_winner;

  assign cpu_first = (last_winner == PORT_LD);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= PORT_LD;
    end else if (cpu_en & ld_en & cpu_req & ld_req) begin
      last_winner <= cpu_gnt ? PORT_CPU : PORT_LD;
    end
  end
`else
  assign cpu_first = 1'b1;
`endif

  mem_arb_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .cpu_en    (cpu_en),
    .ld_en     (ld_en),
    .cpu_first (cpu_first),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .cpu_gnt   (cpu_gnt),
    .ld_gnt    (ld_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  assign cpu_pend_nxt = cpu_gnt & ~cpu_we;
  assign ld_pend_nxt  = ld_gnt & ~ld_we;

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (ld_done && !ld_gnt) state_nxt = RUN;
      RUN:     if (reload_req) state_nxt = DRAIN;
      // DRAIN issues no grants, so the read in flight is delivered this cycle
      DRAIN:   if (!(cpu_pend_nxt || ld_pend_nxt)) state_nxt = BOOT;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BOOT;
      cpu_pend <= 1'b0;
      ld_pend  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      cpu_pend <= cpu_pend_nxt;
      ld_pend  <= ld_pend_nxt;
      if (state == DRAIN && state_nxt == BOOT) begin
        cnt <= '0;
      end else if (state == BOOT && ld_gnt && ld_we && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign cpu_rvalid = cpu_pend & ~reset;
  assign ld_rvalid  = ld_pend & ~reset;
  assign rdata      = mem_rdata;
  assign cpu_hold   = (state != RUN);
  assign mode       = state;
  assign ld_count   = cnt;

endmodule
